register_bank_cnt: RTL and testbench

- Parametrised successor to the single 4-bit loadable register of the TD4 emulator.
- Bank of NREGS registers, each WIDTH bits. Each register supports synchronous load, up/down count with a sticky carry/borrow flag, and a gated read onto the shared load-data bus.
- Sits between the ALU result bus (STOREDATA) and the ALU operand bus (LOADDATA). Replaces discrete A/B register instances.

---
 rtl/register_bank_cnt_pkg.sv | 31 +++
 rtl/register_bank_cnt_reg_cnt_cell.sv | 70 +++++++
 rtl/register_bank_cnt.sv | 76 +++++++
 tb/tb_register_bank_cnt.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_cnt_pkg.sv
// Shared emulator-wide constants for the register bank and its cells.
package register_bank_cnt_pkg;

  // Count direction encoding on the CNT_DN / dn inputs.
  localparam logic CNT_UP = 1'b0;
  localparam logic CNT_DN = 1'b1;

  // Default register width of the emulator datapath.
  localparam int DEF_WIDTH = 4;

  // Cell operation selected for one clock edge; visible for debug and checkers.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } cell_op_e;

  // Resolve the per-cell operation: a load always wins over a count.
  function automatic cell_op_e resolve_op(input logic ld, input logic cnt, input logic dn);
    cell_op_e op;
    op = OP_HOLD;
    if (ld) begin
      op = OP_LOAD;
    end else if (cnt) begin
      op = (dn == CNT_DN) ? OP_DEC : OP_INC;
    end
    return op;
  endfunction

endpackage

// File: rtl/register_bank_cnt_reg_cnt_cell.sv
// One WIDTH-bit loadable up/down counter with a sticky carry/borrow flag.
module reg_cnt_cell
  import register_bank_cnt_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             cnt,
  input  logic             dn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             cf,
  output cell_op_e         op_dbg
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;
  logic             cf_q;
  logic             cf_d;
  cell_op_e         op;

  // Next-state: load clears the flag; a wrap in either direction sets it;
  // a non-wrapping count leaves the flag untouched (sticky).
  always_comb begin
    reg_d = reg_q;
    cf_d  = cf_q;
    op    = resolve_op(ld, cnt, dn);
    case (op)
      OP_LOAD: begin
        reg_d = d;
        cf_d  = 1'b0;
      end
      OP_INC: begin
        reg_d = reg_q + WIDTH'(1);
        if (&reg_q) begin
          cf_d = 1'b1;
        end
      end
      OP_DEC: begin
        reg_d = reg_q - WIDTH'(1);
        if (reg_q == '0) begin
          cf_d = 1'b1;
        end
      end
      default: begin
        reg_d = reg_q;
        cf_d  = cf_q;
      end
    endcase
  end

  // State registers; reset is asynchronous so a half-done update is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q <= RST_VAL;
      cf_q  <= 1'b0;
    end else begin
      reg_q <= reg_d;
      cf_q  <= cf_d;
    end
  end

  assign q      = reg_q;
  assign cf     = cf_q;
  assign op_dbg = op;

endmodule

// File: rtl/register_bank_cnt.sv
// Bank of NREGS loadable up/down counters between the ALU result bus
// (STOREDATA) and the ALU operand bus (LOADDATA). NREGS must be at least 2.
//
// Strobe semantics: nST and CNT_EN are sampled at every rising CLK edge and
// act for exactly that edge; there is no handshake or back-pressure. Indices
// at or above NREGS address nothing: stores/counts are dropped, reads give 0.
module register_bank_cnt
  import register_bank_cnt_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               NREGS   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              SELW    = $clog2(NREGS)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   nST,
  input  logic [SELW-1:0]        ST_SEL,
  input  logic [WIDTH-1:0]       STOREDATA,
  input  logic                   CNT_EN,
  input  logic [SELW-1:0]        CNT_SEL,
  input  logic                   CNT_DN,
  input  logic                   nOUT,
  input  logic [SELW-1:0]        RD_SEL,
  output logic [WIDTH-1:0]       LOADDATA,
  output logic [NREGS*WIDTH-1:0] COUNTER,
  output logic [NREGS-1:0]       CF
);

  logic [NREGS-1:0] ld_vec;
  logic [NREGS-1:0] cnt_vec;
  logic [WIDTH-1:0] reg_val [NREGS];
  cell_op_e         op_dbg  [NREGS];

  // Address decode with load-over-count priority on the same register.
  always_comb begin
    ld_vec  = '0;
    cnt_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      ld_vec[i]  = !nST && (int'(ST_SEL) == i);
      cnt_vec[i] = CNT_EN && (int'(CNT_SEL) == i) && !ld_vec[i];
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cell
    reg_cnt_cell #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk    (CLK),
      .rst    (RST),
      .ld     (ld_vec[g]),
      .cnt    (cnt_vec[g]),
      .dn     (CNT_DN),
      .d      (STOREDATA),
      .q      (reg_val[g]),
      .cf     (CF[g]),
      .op_dbg (op_dbg[g])
    );

    assign COUNTER[g*WIDTH +: WIDTH] = reg_val[g];
  end

  // Zero-latency gated read mux; an unmatched index leaves the bus at zero.
  always_comb begin
    LOADDATA = '0;
    if (!nOUT) begin
      for (int i = 0; i < NREGS; i++) begin
        if (int'(RD_SEL) == i) begin
          LOADDATA = reg_val[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_bank_cnt.sv
// Directed bench for register_bank_cnt: a 2x4-bit default bank and a
// 3x8-bit bank with a non-zero reset value, checked through an expected queue.
module tb_register_bank_cnt;

  localparam int W = 32;

  logic clk = 1'b0;

  // Bank A: WIDTH=4, NREGS=2, RST_VAL=0
  logic       a_rst = 1'b0;
  logic       a_nst = 1'b1;
  logic [0:0] a_st_sel = '0;
  logic [3:0] a_sd = '0;
  logic       a_cnt_en = 1'b0;
  logic [0:0] a_cnt_sel = '0;
  logic       a_cnt_dn = 1'b0;
  logic       a_nout = 1'b1;
  logic [0:0] a_rd_sel = '0;
  logic [3:0] a_ld;
  logic [7:0] a_counter;
  logic [1:0] a_cf;

  // Bank B: WIDTH=8, NREGS=3, RST_VAL=8'h55
  logic        b_rst = 1'b0;
  logic        b_nst = 1'b1;
  logic [1:0]  b_st_sel = '0;
  logic [7:0]  b_sd = '0;
  logic        b_cnt_en = 1'b0;
  logic [1:0]  b_cnt_sel = '0;
  logic        b_cnt_dn = 1'b0;
  logic        b_nout = 1'b1;
  logic [1:0]  b_rd_sel = '0;
  logic [7:0]  b_ld;
  logic [23:0] b_counter;
  logic [2:0]  b_cf;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // clock
  always #5 clk = ~clk;

  register_bank_cnt #(.WIDTH(4), .NREGS(2), .RST_VAL(4'h0)) dut_a (
    .CLK(clk), .RST(a_rst), .nST(a_nst), .ST_SEL(a_st_sel), .STOREDATA(a_sd),
    .CNT_EN(a_cnt_en), .CNT_SEL(a_cnt_sel), .CNT_DN(a_cnt_dn),
    .nOUT(a_nout), .RD_SEL(a_rd_sel),
    .LOADDATA(a_ld), .COUNTER(a_counter), .CF(a_cf)
  );

  register_bank_cnt #(.WIDTH(8), .NREGS(3), .RST_VAL(8'h55)) dut_b (
    .CLK(clk), .RST(b_rst), .nST(b_nst), .ST_SEL(b_st_sel), .STOREDATA(b_sd),
    .CNT_EN(b_cnt_en), .CNT_SEL(b_cnt_sel), .CNT_DN(b_cnt_dn),
    .nOUT(b_nout), .RD_SEL(b_rd_sel),
    .LOADDATA(b_ld), .COUNTER(b_counter), .CF(b_cf)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_val(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  // scoreboard: pop the oldest expectation and compare
  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    // reset asserted mid-cycle with no clock edge
    #3;
    a_rst = 1'b1;
    b_rst = 1'b1;
    settle();
    expect_val(32'h00);     check("a_reset_counter", W'(a_counter));
    expect_val(32'h0);      check("a_reset_cf", W'(a_cf));
    expect_val(32'h0);      check("a_reset_loaddata", W'(a_ld));
    expect_val(32'h555555); check("b_reset_counter", W'(b_counter));
    expect_val(32'h0);      check("b_reset_cf", W'(b_cf));
    @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // store A to reg1, read gated
    a_nst = 1'b0; a_st_sel = 1'b1; a_sd = 4'hA;
    tick();
    a_nst = 1'b1;
    a_nout = 1'b0; a_rd_sel = 1'b1;
    settle();
    expect_val(32'hA);  check("a_read_reg1", W'(a_ld));
    a_nout = 1'b1;
    settle();
    expect_val(32'h0);  check("a_read_gated", W'(a_ld));
    expect_val(32'hA0); check("a_counter_after_store", W'(a_counter));

    // same-cycle write/read returns old value before the edge
    a_nst = 1'b0; a_st_sel = 1'b1; a_sd = 4'h7;
    a_nout = 1'b0; a_rd_sel = 1'b1;
    settle();
    expect_val(32'hA);  check("a_read_old_during_write", W'(a_ld));
    tick();
    expect_val(32'h7);  check("a_read_new_after_write", W'(a_ld));
    a_sd = 4'hA;
    tick();
    a_nst = 1'b1; a_nout = 1'b1;

    // load E into reg0, count up across the wrap
    a_nst = 1'b0; a_st_sel = 1'b0; a_sd = 4'hE;
    tick();
    a_nst = 1'b1;
    expect_val(32'hAE); check("a_load_e", W'(a_counter));
    a_cnt_en = 1'b1; a_cnt_sel = 1'b0; a_cnt_dn = 1'b0;
    tick();
    expect_val(32'hAF); check("a_up_f", W'(a_counter));
    expect_val(32'h0);  check("a_up_f_cf", W'(a_cf));
    tick();
    expect_val(32'hA0); check("a_up_wrap", W'(a_counter));
    expect_val(32'h1);  check("a_up_wrap_cf", W'(a_cf));
    tick();
    a_cnt_en = 1'b0;
    expect_val(32'hA1); check("a_up_1", W'(a_counter));
    expect_val(32'h1);  check("a_cf_sticky", W'(a_cf));
    tick();
    expect_val(32'hA1); check("a_hold", W'(a_counter));
    expect_val(32'h1);  check("a_hold_cf", W'(a_cf));
    a_nst = 1'b0; a_st_sel = 1'b0; a_sd = 4'h3;
    tick();
    a_nst = 1'b1;
    expect_val(32'hA3); check("a_load_3", W'(a_counter));
    expect_val(32'h0);  check("a_load_clears_cf", W'(a_cf));

    // reg1 = 0, count down with borrow, then a non-wrapping decrement
    a_nst = 1'b0; a_st_sel = 1'b1; a_sd = 4'h0;
    tick();
    a_nst = 1'b0; a_st_sel = 1'b1; a_nst = 1'b1;
    a_cnt_en = 1'b1; a_cnt_sel = 1'b1; a_cnt_dn = 1'b1;
    tick();
    expect_val(32'hF3); check("a_dn_borrow", W'(a_counter));
    expect_val(32'h2);  check("a_dn_borrow_cf", W'(a_cf));
    tick();
    a_cnt_en = 1'b0;
    expect_val(32'hE3); check("a_dn_e", W'(a_counter));
    expect_val(32'h2);  check("a_dn_cf_held", W'(a_cf));

    // load beats count on the same register
    a_nst = 1'b0; a_st_sel = 1'b0; a_sd = 4'h9;
    tick();
    a_sd = 4'h5;
    a_cnt_en = 1'b1; a_cnt_sel = 1'b0; a_cnt_dn = 1'b0;
    tick();
    expect_val(32'hE5); check("a_load_wins", W'(a_counter));
    expect_val(32'h2);  check("a_load_wins_cf", W'(a_cf));
    // load reg0 while counting reg1 up
    a_cnt_sel = 1'b1;
    tick();
    a_nst = 1'b1; a_cnt_en = 1'b0;
    expect_val(32'hF5); check("a_load_and_count", W'(a_counter));

    // bank B: store FF to index 2, then wrap it up
    b_nst = 1'b0; b_st_sel = 2'd2; b_sd = 8'hFF;
    tick();
    b_nst = 1'b1;
    expect_val(32'hFF5555); check("b_store_ff", W'(b_counter));
    b_cnt_en = 1'b1; b_cnt_sel = 2'd2; b_cnt_dn = 1'b0;
    tick();
    b_cnt_en = 1'b0;
    expect_val(32'h005555); check("b_up_wrap", W'(b_counter));
    expect_val(32'h4);      check("b_up_wrap_cf", W'(b_cf));

    // out-of-range index: reads 0, store/count do nothing
    b_nout = 1'b0; b_rd_sel = 2'd3;
    settle();
    expect_val(32'h0);  check("b_read_oob", W'(b_ld));
    b_rd_sel = 2'd1;
    settle();
    expect_val(32'h55); check("b_read_reg1", W'(b_ld));
    b_nst = 1'b0; b_st_sel = 2'd3; b_sd = 8'hAA;
    b_cnt_en = 1'b1; b_cnt_sel = 2'd3; b_cnt_dn = 1'b1;
    tick();
    b_nst = 1'b1; b_cnt_en = 1'b0;
    expect_val(32'h005555); check("b_oob_no_effect", W'(b_counter));
    expect_val(32'h4);      check("b_oob_cf", W'(b_cf));

    // reset during a count-enabled cycle, away from the edge
    b_cnt_en = 1'b1; b_cnt_sel = 2'd0; b_cnt_dn = 1'b0;
    b_rd_sel = 2'd2;
    @(negedge clk);
    b_rst = 1'b1;
    settle();
    expect_val(32'h555555); check("b_async_reset", W'(b_counter));
    expect_val(32'h0);      check("b_async_reset_cf", W'(b_cf));
    expect_val(32'h55);     check("b_async_reset_read", W'(b_ld));
    tick();
    expect_val(32'h555555); check("b_reset_holds", W'(b_counter));
    @(negedge clk);
    b_rst = 1'b0;
    tick();
    b_cnt_en = 1'b0;
    expect_val(32'h555556); check("b_count_after_reset", W'(b_counter));

    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL leftover_expectations: observed %0d queued expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
